// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline sequencer for the five-stage integer core.
//                Produces stall / bubble / flush controls, operand-forwarding
//                selects and the gated JALR redirect, and freezes the pipe
//                while a data-memory access is outstanding.
//                Optional macro HAZARD_PERF_EN builds the stall/flush
//                performance counters; without it both counter ports are 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int RFIDX_WIDTH  = 5,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [RFIDX_WIDTH-1:0] id_rs1_index,
    input  logic [RFIDX_WIDTH-1:0] id_rs2_index,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic [RFIDX_WIDTH-1:0] id_rd_index,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   id_jalr_en,
    input  logic                   ex_bxx_taken,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   pc_stall,
    output logic                   ifid_stall,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic                   pipe_freeze,
    output logic                   bxx_flush,
    output logic                   jalr_go,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic [31:0]            stall_cnt,
    output logic [31:0]            flush_cnt
);

    localparam logic [1:0] c_st_run    = 2'd0;
    localparam logic [1:0] c_st_freeze = 2'd1;
    localparam logic [1:0] c_st_flush  = 2'd2;

    localparam logic [1:0]             c_flush_load = 2'(FLUSH_CYCLES - 1);
    localparam logic [RFIDX_WIDTH-1:0] c_x0         = '0;

    logic [1:0]             r_state;
    logic [1:0]             r_flush_left;
    logic                   r_flush_pend;
    logic [RFIDX_WIDTH-1:0] r_ex_rd;
    logic                   r_ex_wr;
    logic                   r_ex_ld;
    logic [RFIDX_WIDTH-1:0] r_mem_rd;
    logic                   r_mem_wr;
    logic [RFIDX_WIDTH-1:0] r_wb_rd;
    logic                   r_wb_wr;

    logic [1:0] w_state_nxt;
    logic [1:0] w_flush_left_nxt;
    logic       w_flush_pend_nxt;
    logic       w_load_use;
    logic       w_lu_stall;
    logic       w_pc_stall;
    logic       w_ifid_stall;
    logic       w_ifid_flush;
    logic       w_idex_bubble;
    logic       w_pipe_freeze;
    logic       w_bxx_flush;
    logic       w_jalr_go;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // A load still in EX whose result decode needs right now.
    assign w_load_use = id_valid & r_ex_ld & r_ex_wr & (r_ex_rd != c_x0) &
                        ((id_rs1_used & (id_rs1_index == r_ex_rd)) |
                         (id_rs2_used & (id_rs2_index == r_ex_rd)));

    // Operand forwarding: the younger EX/MEM result beats MEM/WB; x0 never forwards.
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (r_mem_wr && (r_mem_rd != c_x0) && (r_mem_rd == id_rs1_index))
            w_fwd_a = 2'b10;
        else if (r_wb_wr && (r_wb_rd != c_x0) && (r_wb_rd == id_rs1_index))
            w_fwd_a = 2'b01;
        if (r_mem_wr && (r_mem_rd != c_x0) && (r_mem_rd == id_rs2_index))
            w_fwd_b = 2'b10;
        else if (r_wb_wr && (r_wb_rd != c_x0) && (r_wb_rd == id_rs2_index))
            w_fwd_b = 2'b01;
    end

    // Next-state and control outputs; priority freeze > branch flush > load-use > jalr.
    always_comb begin
        w_state_nxt      = r_state;
        w_flush_left_nxt = r_flush_left;
        w_flush_pend_nxt = r_flush_pend;
        w_lu_stall       = 1'b0;
        w_pc_stall       = 1'b0;
        w_ifid_stall     = 1'b0;
        w_ifid_flush     = 1'b0;
        w_idex_bubble    = 1'b0;
        w_pipe_freeze    = 1'b0;
        w_bxx_flush      = 1'b0;
        w_jalr_go        = 1'b0;
        case (r_state)
            c_st_run: begin
                w_jalr_go = id_jalr_en & id_valid & ~w_load_use & ~ex_bxx_taken;
                if (mem_req && !mem_ready) begin
                    // A branch resolving now must wait until the access completes.
                    w_state_nxt      = c_st_freeze;
                    w_flush_pend_nxt = ex_bxx_taken;
                    w_lu_stall       = w_load_use;
                end else if (ex_bxx_taken) begin
                    w_state_nxt      = c_st_flush;
                    w_flush_left_nxt = c_flush_load;
                end else begin
                    w_lu_stall = w_load_use;
                end
                w_pc_stall    = w_lu_stall;
                w_ifid_stall  = w_lu_stall;
                w_idex_bubble = w_lu_stall;
                w_ifid_flush  = w_jalr_go;
            end
            c_st_freeze: begin
                w_pc_stall    = 1'b1;
                w_ifid_stall  = 1'b1;
                w_pipe_freeze = 1'b1;
                if (mem_ready) begin
                    if (r_flush_pend) begin
                        w_state_nxt      = c_st_flush;
                        w_flush_left_nxt = c_flush_load;
                        w_flush_pend_nxt = 1'b0;
                    end else begin
                        w_state_nxt = c_st_run;
                    end
                end
            end
            c_st_flush: begin
                w_bxx_flush   = 1'b1;
                w_ifid_flush  = 1'b1;
                w_idex_bubble = 1'b1;
                if (r_flush_left == 2'd0)
                    w_state_nxt = c_st_run;
                else
                    w_flush_left_nxt = r_flush_left - 2'd1;
            end
            default: begin
                w_state_nxt = c_st_run;
            end
        endcase
    end

    // State register, flush timer and EX/MEM/WB destination shadows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_st_run;
            r_flush_left <= 2'd0;
            r_flush_pend <= 1'b0;
            r_ex_rd      <= '0;
            r_ex_wr      <= 1'b0;
            r_ex_ld      <= 1'b0;
            r_mem_rd     <= '0;
            r_mem_wr     <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_wr      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_left <= w_flush_left_nxt;
            r_flush_pend <= w_flush_pend_nxt;
            if (!w_pipe_freeze) begin
                if (w_idex_bubble || w_bxx_flush) begin
                    r_ex_rd <= '0;
                    r_ex_wr <= 1'b0;
                    r_ex_ld <= 1'b0;
                end else begin
                    r_ex_rd <= id_rd_index;
                    r_ex_wr <= id_reg_write;
                    r_ex_ld <= id_mem_read;
                end
                r_mem_rd <= r_ex_rd;
                r_mem_wr <= r_ex_wr;
                r_wb_rd  <= r_mem_rd;
                r_wb_wr  <= r_mem_wr;
            end
        end
    end

    assign pc_stall    = rst_n & w_pc_stall;
    assign ifid_stall  = rst_n & w_ifid_stall;
    assign ifid_flush  = rst_n & w_ifid_flush;
    assign idex_bubble = rst_n & w_idex_bubble;
    assign pipe_freeze = rst_n & w_pipe_freeze;
    assign bxx_flush   = rst_n & w_bxx_flush;
    assign jalr_go     = rst_n & w_jalr_go;
    assign fwd_a_sel   = {2{rst_n}} & w_fwd_a;
    assign fwd_b_sel   = {2{rst_n}} & w_fwd_b;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_stall_evt;
    logic        w_flush_enter;

    assign w_stall_evt   = w_lu_stall | (r_state == c_st_freeze);
    assign w_flush_enter = (w_state_nxt == c_st_flush) & (r_state != c_st_flush);

    // Free-running wrap-around event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_stall_evt)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_flush_enter)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = {32{rst_n}} & r_stall_cnt;
    assign flush_cnt = {32{rst_n}} & r_flush_cnt;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
